// File: rtl/veda_fetch_decode.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a MIPS-like core.
// Each instruction takes FETCH, DECODE, EXECUTE and WRITEBACK, with one cycle each when memory acks at once.
module veda_fetch_decode #(
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        write_enable,
    output logic        instruction_check,
    input  logic        alu_zero,
    output logic        busy,
    output logic        halted,
    output logic [31:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [31:0] count_reg, count_next;
    logic        zero_reg, zero_next;

    logic [31:0] imm_sext;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc_plus1;
    logic        is_write_op;
    logic [4:0]  dest_idx;

    // Field outputs come straight from the instruction register, so they only change on an acked fetch.
    assign opcode = ir_reg[31:26];
    assign rs     = ir_reg[25:21];
    assign rt     = ir_reg[20:16];
    assign rd     = ir_reg[15:11];
    assign funct  = ir_reg[5:0];
    assign imm    = ir_reg[15:0];

    assign imm_sext[15:0] = ir_reg[15:0];
    generate
        for (genvar gi = 16; gi < 32; gi++) begin : g_sext
            assign imm_sext[gi] = ir_reg[15];
        end
    endgenerate

    assign pc_plus1      = pc_reg + 32'd1;
    assign branch_target = pc_plus1 + imm_sext;
    assign jump_target   = {6'd0, ir_reg[25:0]};

    assign is_write_op = (opcode == OP_RTYPE) || (opcode == OP_ADDI) ||
                         (opcode == OP_ANDI)  || (opcode == OP_ORI);
    assign instruction_check = (opcode != OP_RTYPE);
    assign dest_idx = instruction_check ? rt : rd;

    assign imem_req     = (state_reg == S_FETCH);
    assign imem_addr    = pc_reg;
    assign busy         = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                          (state_reg == S_EXECUTE) || (state_reg == S_WRITEBACK);
    assign halted       = (state_reg == S_HALT);
    assign instr_count  = count_reg;
    // Writes to register 0 are suppressed so $0 stays hard-wired to zero.
    assign write_enable = (state_reg == S_WRITEBACK) && is_write_op && (dest_idx != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= 32'd0;
            ir_reg    <= 32'd0;
            count_reg <= 32'd0;
            zero_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            count_reg <= count_next;
            zero_reg  <= zero_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        count_next = count_reg;
        zero_next  = zero_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = 32'd0;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                state_next = (opcode == HALT_OP) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                zero_next  = alu_zero;
                state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (opcode == OP_BEQ && zero_reg) begin
                    pc_next = branch_target;
                end else if (opcode == OP_J) begin
                    pc_next = jump_target;
                end else begin
                    pc_next = pc_plus1;
                end
                count_next = count_reg + 32'd1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_veda_fetch_decode.sv
// Self-checking bench for veda_fetch_decode: an instruction-level reference model tracks pc,
// instruction count and expected writes while the bench plays instruction memory and ALU.
module tb_veda_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  opcode, funct;
    logic        write_enable, instruction_check;
    logic        alu_zero = 1'b0;
    logic        busy, halted;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] pc_m;
    logic [31:0] cnt_m;
    logic [31:0] ir_m;

    veda_fetch_decode #(.HALT_OP(6'h3F)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .opcode(opcode), .funct(funct),
        .write_enable(write_enable), .instruction_check(instruction_check),
        .alu_zero(alu_zero), .busy(busy), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pc_m = 32'd0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            errors++;
            $display("FAIL start_fetch: req=%0b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    // Runs one instruction from a FETCH negedge; returns at the next FETCH negedge (or in HALT).
    // abort_wb asserts reset during WRITEBACK instead of completing the instruction.
    task automatic run_instr(input logic [31:0] instr, input int delay, input logic zero,
                             input bit rand_start, input bit abort_wb);
        logic [5:0]  op;
        logic [4:0]  dest;
        logic        exp_we;
        logic        exp_ic;
        logic [31:0] next_pc;
        logic [15:0] i16;
        op   = instr[31:26];
        exp_ic = (op != 6'h00);
        dest = exp_ic ? instr[20:16] : instr[15:11];
        exp_we = (op == 6'h00 || op == 6'h08 || op == 6'h0C || op == 6'h0D) && (dest != 5'd0);
        i16 = instr[15:0];
        if (op == 6'h04 && zero)
            next_pc = pc_m + 32'd1 + 32'(int'(shortint'(i16)));
        else if (op == 6'h02)
            next_pc = 32'(instr[25:0]);
        else
            next_pc = pc_m + 32'd1;

        checks++;
        if (imem_req !== 1'b1 || imem_addr !== pc_m) begin
            errors++;
            $display("FAIL fetch_addr: req=%0b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, pc_m);
        end
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom;
            if (rand_start) start = 1'($urandom);
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== pc_m || busy !== 1'b1 ||
                {opcode, rs, rt, rd, funct, imm} !== {ir_m[31:26], ir_m[25:21], ir_m[20:16], ir_m[15:11], ir_m[5:0], ir_m[15:0]}) begin
                errors++;
                $display("FAIL fetch_wait: req=%0b addr=%h op=%h imm=%h, expected req=1 addr=%h op=%h imm=%h",
                         imem_req, imem_addr, opcode, imm, pc_m, ir_m[31:26], ir_m[15:0]);
            end
        end
        imem_ack = 1'b1;
        imem_rdata = instr;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        ir_m = instr;
        // DECODE
        checks++;
        if (opcode !== instr[31:26] || rs !== instr[25:21] || rt !== instr[20:16] || rd !== instr[15:11] ||
            funct !== instr[5:0] || imm !== instr[15:0] || instruction_check !== exp_ic) begin
            errors++;
            $display("FAIL decode_fields: op=%h rs=%0d rt=%0d rd=%0d funct=%h imm=%h ic=%0b, expected instr=%h ic=%0b",
                     opcode, rs, rt, rd, funct, imm, instruction_check, instr, exp_ic);
        end
        checks++;
        if (imem_req !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL decode_ctrl: req=%0b we=%0b busy=%0b, expected 0 0 1", imem_req, write_enable, busy);
        end
        if (op == 6'h3F) begin
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || instr_count !== cnt_m) begin
                errors++;
                $display("FAIL halt_enter: halted=%0b busy=%0b req=%0b count=%0d, expected 1 0 0 %0d",
                         halted, busy, imem_req, instr_count, cnt_m);
            end
            $display("instr pc=%h ir=%h -> HALT count=%0d", pc_m, instr, instr_count);
            return;
        end
        alu_zero = ~zero;
        if (rand_start) start = 1'($urandom);
        @(negedge clk);
        // EXECUTE: only now does alu_zero carry the real flag
        alu_zero = zero;
        checks++;
        if (write_enable !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL execute_ctrl: we=%0b busy=%0b, expected 0 1", write_enable, busy);
        end
        @(negedge clk);
        // WRITEBACK
        alu_zero = ~zero;
        checks++;
        if (write_enable !== exp_we || instruction_check !== exp_ic || busy !== 1'b1) begin
            errors++;
            $display("FAIL writeback_we: we=%0b ic=%0b busy=%0b, expected we=%0b ic=%0b busy=1",
                     write_enable, instruction_check, busy, exp_we, exp_ic);
        end
        if (abort_wb) begin
            rst_n = 1'b0;
            #1;
            checks++;
            if (write_enable !== 1'b0 || instr_count !== 32'd0 || busy !== 1'b0 || imem_req !== 1'b0 ||
                opcode !== 6'd0 || imm !== 16'd0 || imem_addr !== 32'd0 || halted !== 1'b0) begin
                errors++;
                $display("FAIL abort_wb: we=%0b count=%0d busy=%0b req=%0b op=%h imm=%h addr=%h, expected all 0",
                         write_enable, instr_count, busy, imem_req, opcode, imm, imem_addr);
            end
            @(negedge clk);
            rst_n = 1'b1;
            pc_m = 32'd0; cnt_m = 32'd0; ir_m = 32'd0;
            $display("instr pc=%h ir=%h -> aborted by reset in writeback", pc_m, instr);
            return;
        end
        @(negedge clk);
        start = 1'b0;
        pc_m = next_pc;
        cnt_m = cnt_m + 32'd1;
        checks++;
        if (write_enable !== 1'b0 || instr_count !== cnt_m || imem_req !== 1'b1 || imem_addr !== pc_m) begin
            errors++;
            $display("FAIL next_fetch: we=%0b count=%0d req=%0b addr=%h, expected we=0 count=%0d req=1 addr=%h",
                     write_enable, instr_count, imem_req, imem_addr, cnt_m, pc_m);
        end
        $display("instr ir=%h delay=%0d zero=%0b we=%0b next_pc=%h count=%0d", instr, delay, zero, exp_we, pc_m, instr_count);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || write_enable !== 1'b0 || busy !== 1'b0 || halted !== 1'b0 ||
            instr_count !== 32'd0 || imem_addr !== 32'd0 || {rs, rt, rd, imm, opcode, funct} !== 43'd0) begin
            errors++;
            $display("FAIL reset_state: req=%0b we=%0b busy=%0b halted=%0b count=%0d addr=%h, expected all 0",
                     imem_req, write_enable, busy, halted, instr_count, imem_addr);
        end
        rst_n = 1'b1;
        pc_m = 32'd0; cnt_m = 32'd0; ir_m = 32'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: req=%0b busy=%0b, expected 0 0", imem_req, busy);
        end
        $display("reset: idle with count=%0d", instr_count);
    endtask

    task automatic test_addi();
        do_start();
        run_instr(32'h20030005, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_rtype_zero_dest();
        run_instr(32'h00220020, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h00221820, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(32'h0800000A, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h1000FFFE, 0, 1'b1, 1'b0, 1'b0);
        run_instr(32'h0800000A, 0, 1'b0, 1'b0, 1'b0);
        run_instr(32'h1000FFFE, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_delayed_ack();
        run_instr(32'h3464ABCD, 3, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h02, 6'h10, 6'h23};
        for (int n = 0; n < 40; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[31:26] = ops[$urandom_range(0, 7)];
            run_instr(w, $urandom_range(0, 3), 1'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic test_pc_wrap();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_m = 32'd0; ir_m = 32'd0;
        @(negedge clk);
        do_start();
        run_instr(32'h1000FFFE, 0, 1'b1, 1'b0, 1'b0);
        run_instr(32'hF0000000, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        run_instr(32'h20070009, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_stays_idle: req=%0b busy=%0b count=%0d, expected 0 0 0", imem_req, busy, instr_count);
        end
        do_start();
        imem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_fetch: req=%0b busy=%0b count=%0d, expected 0 0 0", imem_req, busy, instr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        run_instr(32'h20030005, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        run_instr(32'hFC000000, 1, 1'b0, 1'b0, 1'b0);
        frozen = cnt_m;
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom);
            imem_ack = 1'($urandom);
            @(negedge clk);
            checks++;
            if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || write_enable !== 1'b0 || instr_count !== frozen) begin
                errors++;
                $display("FAIL halt_hold: halted=%0b busy=%0b req=%0b we=%0b count=%0d, expected 1 0 0 0 %0d",
                         halted, busy, imem_req, write_enable, instr_count, frozen);
            end
        end
        start = 1'b0;
        imem_ack = 1'b0;
        $display("halt: held for 20 cycles with count=%0d", instr_count);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_rtype_zero_dest();
        test_beq();
        test_delayed_ack();
        test_random();
        test_pc_wrap();
        test_reset_abort();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/veda_fetch_decode.md
VEDA_FETCH_DECODE -- requirements
Module: veda_fetch_decode

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: start  input  1  begin execution from PC 0 (sampled in IDLE only).
REQ-004 SHALL have ports: imem_req  output  1; imem_addr  output  32; imem_ack  input  1; imem_rdata  input  32 (instruction fetch handshake, word-addressed).
REQ-005 SHALL have ports: rs, rt, rd  output  5 each; imm  output  16; opcode  output  6; funct  output  6 (decoded fields driving the register file and ALU).
REQ-006 SHALL have ports: write_enable  output  1; instruction_check  output  1 (1 = destination rt, 0 = destination rd).
REQ-007 SHALL have ports: alu_zero  input  1  ALU equality flag for beq.
REQ-008 SHALL have ports: busy  output  1; halted  output  1; instr_count  output  32.
REQ-009 SHALL have parameter HALT_OP, default 6'h3F, meaning opcode that stops execution.

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-011 IDLE: start=1 -> FETCH next cycle with pc=0; start=0 -> remain IDLE.
REQ-012 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1 capture imem_rdata into instruction register, -> DECODE; no ack -> stay, req held, addr stable.
REQ-013 imem_req SHALL be 0 in every state except FETCH; imem_rdata ignored when imem_ack=0.
REQ-014 Field decode SHALL be opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0], all stable from DECODE through WRITEBACK.
REQ-015 DECODE: one cycle, -> EXECUTE; opcode==HALT_OP -> HALT instead.
REQ-016 EXECUTE: one cycle, sample alu_zero, -> WRITEBACK.
REQ-017 Writing instructions: opcode 6'h00 (R-type, instruction_check=0), 6'h08/6'h0C/6'h0D (addi/andi/ori, instruction_check=1).
REQ-018 WRITEBACK: write_enable=1 for exactly one cycle for writing instructions, except when destination index (rd or rt per instruction_check) is 0 -> write_enable=0.
REQ-019 write_enable SHALL be 0 in every state other than WRITEBACK.
REQ-020 instruction_check SHALL be 0 for opcode 6'h00, 1 for all other opcodes.
REQ-021 Next pc at WRITEBACK exit: beq (6'h04) with sampled alu_zero=1 -> pc+1+sign-extend(imm); j (6'h02) -> zero-extend([25:0]); otherwise pc+1; all arithmetic modulo 2^32 (wrap 32'hFFFFFFFF -> 0).
REQ-022 Unlisted opcodes SHALL execute as NOP: no write, pc+1, counted.
REQ-023 WRITEBACK -> FETCH; instr_count +1 on WRITEBACK exit, wraps at 2^32.
REQ-024 HALT: halted=1, no fetch, no write, instr_count frozen, HALT not counted; exit only via reset.
REQ-025 busy=1 in FETCH, DECODE, EXECUTE, WRITEBACK; 0 in IDLE and HALT.
REQ-026 start SHALL be ignored outside IDLE.
REQ-027 Minimum latency per instruction SHALL be 4 cycles with imem_ack asserted on first FETCH cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, pc=0, instr_count=0, instruction register=0, imem_req=0, write_enable=0, busy=0, halted=0, all field outputs 0.
REQ-029 Reset asserted mid-FETCH or mid-WRITEBACK SHALL abort with no write and no count increment; operation resumes only on a later start.

Verification
REQ-030 start, imem always ack, mem[0]=addi $3,$0,5 (0x20030005) -> write_enable one cycle, rt=3, instruction_check=1, imm=5, instr_count=1, next imem_addr=1.
REQ-031 R-type add $0 target (rd=0) -> write_enable stays 0, instr_count increments.
REQ-032 beq at pc=10, imm=16'hFFFE, alu_zero=1 -> next imem_addr=9; alu_zero=0 -> 11.
REQ-033 imem_ack delayed 3 cycles -> imem_req/imem_addr stable 4 cycles, no field change, then normal decode.
REQ-034 instruction 0xFC000000 -> halted=1, busy=0, imem_req=0 forever, start ignored, instr_count unchanged.
REQ-035 rst_n low during WRITEBACK of addi -> write_enable falls same instant, instr_count=0, state IDLE.
